// File: rtl/mini_src_control_unit.sv
// Hardwired control sequencer for the Mini SRC single-bus datapath.
// Shared fetch in T0-T2, opcode-specific execute in T3-T7, memory steps stretched by mem_ready.
module mini_src_control_unit #(
  parameter int unsigned    OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = OPW'(5'b00011)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] ir_opcode,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           ZLowOut,
  output logic           MDRout,
  output logic           BAout,
  output logic           Cout,
  output logic           Rout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Rin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           MDRread,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StT7   = 4'd8,
    StHalt = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    ClLd,
    ClLdi,
    ClSt,
    ClAluR,
    ClAluI,
    ClNop,
    ClHalt,
    ClBad
  } op_class_e;

  function automatic op_class_e classify(input logic [OPW-1:0] op);
    op_class_e cls;
    cls = ClBad;
    if (op == OPW'(0)) begin
      cls = ClLd;
    end else if (op == OPW'(1)) begin
      cls = ClLdi;
    end else if (op == OPW'(2)) begin
      cls = ClSt;
    end else if (op >= OPW'(3) && op <= OPW'(11)) begin
      cls = ClAluR;
    end else if (op >= OPW'(12) && op <= OPW'(14)) begin
      cls = ClAluI;
    end else if (op == OPW'(26)) begin
      cls = ClNop;
    end else if (op == OPW'(27)) begin
      cls = ClHalt;
    end
    return cls;
  endfunction

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           illegal_q, illegal_d;
  logic           fetch_wait_q, fetch_wait_d;
  op_class_e      cls;

  // T3 decodes the live IR; later steps use the copy latched on leaving T3.
  assign cls = classify((state_q == StT3) ? ir_opcode : op_q);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    illegal_d    = illegal_q;
    fetch_wait_d = 1'b0;
    case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1: begin
        if (mem_ready) begin
          state_d = StT2;
        end else begin
          fetch_wait_d = 1'b1;
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        op_d = ir_opcode;
        case (cls)
          ClLd, ClLdi, ClSt, ClAluR, ClAluI: state_d = StT4;
          ClHalt: state_d = StHalt;
          ClNop:  state_d = StT0;
          default: begin
            illegal_d = 1'b1;
            state_d   = StT0;
          end
        endcase
      end
      StT4: state_d = StT5;
      StT5: state_d = (cls == ClLd || cls == ClSt) ? StT6 : StT0;
      StT6: begin
        if (cls == ClSt || mem_ready) begin
          state_d = StT7;
        end
      end
      StT7: begin
        if (cls == ClLd || mem_ready) begin
          state_d = StT0;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= StRst;
      op_q         <= '0;
      illegal_q    <= 1'b0;
      fetch_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      illegal_q    <= illegal_d;
      fetch_wait_q <= fetch_wait_d;
    end
  end

  always_comb begin
    PCout   = 1'b0;
    ZLowOut = 1'b0;
    MDRout  = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    Rout    = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Rin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    MDRread = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    alu_op  = '0;
    run     = (state_q != StHalt);
    illegal = illegal_q;
    state   = state_q;
    case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        ZLowOut = 1'b1;
        PCin    = !fetch_wait_q;  // PC updates only once even if the read stalls
        Read    = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        case (cls)
          ClLd, ClLdi, ClSt: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          ClAluR, ClAluI: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        Zin = 1'b1;
        case (cls)
          ClLd, ClLdi, ClSt: begin
            Cout   = 1'b1;
            alu_op = ADD_OP;
          end
          ClAluR: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            alu_op = op_q;
          end
          ClAluI: begin
            Cout   = 1'b1;
            alu_op = op_q;
          end
          default: Zin = 1'b0;
        endcase
      end
      StT5: begin
        ZLowOut = 1'b1;
        if (cls == ClLd || cls == ClSt) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      StT6: begin
        MDRin = 1'b1;
        if (cls == ClSt) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end else begin
          Read    = 1'b1;
          MDRread = 1'b1;
        end
      end
      StT7: begin
        if (cls == ClSt) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr)
    $onehot0({PCout, ZLowOut, MDRout, BAout, Cout, Rout}));

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench for mini_src_control_unit: a driver pushes the expected per-cycle control word
// derived from instruction-level rules; a monitor pops and compares on every falling edge.
module tb_mini_src_control_unit;

  logic       clk;
  logic       clr;
  logic [4:0] ir_opcode;
  logic       mem_ready;
  logic PCout, ZLowOut, MDRout, BAout, Cout, Rout, MARin, PCin, MDRin, IRin, Yin, Zin, Rin;
  logic IncPC, Read, Write, MDRread, Gra, Grb, Grc, run, illegal;
  logic [4:0] alu_op;
  logic [3:0] state;

  mini_src_control_unit dut (
    .clk       (clk),
    .clr       (clr),
    .ir_opcode (ir_opcode),
    .mem_ready (mem_ready),
    .PCout     (PCout),
    .ZLowOut   (ZLowOut),
    .MDRout    (MDRout),
    .BAout     (BAout),
    .Cout      (Cout),
    .Rout      (Rout),
    .MARin     (MARin),
    .PCin      (PCin),
    .MDRin     (MDRin),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Rin       (Rin),
    .IncPC     (IncPC),
    .Read      (Read),
    .Write     (Write),
    .MDRread   (MDRread),
    .Gra       (Gra),
    .Grb       (Grb),
    .Grc       (Grc),
    .alu_op    (alu_op),
    .run       (run),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3, ST_T3 = 4'd4;
  localparam logic [3:0] ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8, ST_HALT = 4'd9;

  localparam logic [19:0] M_PCOUT = 20'h00001, M_ZLOW = 20'h00002, M_MDROUT = 20'h00004;
  localparam logic [19:0] M_BAOUT = 20'h00008, M_COUT = 20'h00010, M_ROUT = 20'h00020;
  localparam logic [19:0] M_MARIN = 20'h00040, M_PCIN = 20'h00080, M_MDRIN = 20'h00100;
  localparam logic [19:0] M_IRIN = 20'h00200, M_YIN = 20'h00400, M_ZIN = 20'h00800;
  localparam logic [19:0] M_RIN = 20'h01000, M_INCPC = 20'h02000, M_READ = 20'h04000;
  localparam logic [19:0] M_WRITE = 20'h08000, M_MDRREAD = 20'h10000, M_GRA = 20'h20000;
  localparam logic [19:0] M_GRB = 20'h40000, M_GRC = 20'h80000;
  localparam logic [4:0]  ADD = 5'b00011;

  localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_R = 3, C_I = 4, C_NOP = 5, C_HALT = 6;
  localparam int C_BAD = 7;

  typedef struct packed {
    logic [19:0] s;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    logic [3:0]  st;
  } vec_t;

  vec_t  exp_q[$];
  vec_t  act;
  logic  ill_m;
  int    checks;
  int    errors;

  assign act.s = {Grc, Grb, Gra, MDRread, Write, Read, IncPC, Rin, Zin, Yin, IRin, MDRin, PCin,
                  MARin, Rout, Cout, BAout, MDRout, ZLowOut, PCout};
  assign act.alu = alu_op;
  assign act.run = run;
  assign act.ill = illegal;
  assign act.st  = state;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: got strobes=%h alu=%h run=%b ill=%b st=%0d, want strobes=%h alu=%h run=%b ill=%b st=%0d",
                 $time, act.s, act.alu, act.run, act.ill, act.st, e.s, e.alu, e.run, e.ill, e.st);
      end
    end
  end

  function automatic int cls_of(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0) return C_LD;
    if (v == 1) return C_LDI;
    if (v == 2) return C_ST;
    if (v >= 3 && v <= 11) return C_R;
    if (v >= 12 && v <= 14) return C_I;
    if (v == 26) return C_NOP;
    if (v == 27) return C_HALT;
    return C_BAD;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom_range(0, 31));
  endfunction

  // Called just after a rising edge: drive this cycle's inputs, queue the expectation, advance.
  task automatic step(input logic [19:0] m, input logic [4:0] alu, input logic [3:0] st,
                      input logic mr, input logic [4:0] op);
    vec_t e;
    mem_ready = mr;
    ir_opcode = op;
    e.s   = m;
    e.alu = alu;
    e.run = (st != ST_HALT);
    e.ill = ill_m;
    e.st  = st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    clr   = 1'b0;
    ill_m = 1'b0;
    for (int i = 0; i < n; i++) step(20'h0, 5'h0, ST_RST, rbit(), rop());
    clr = 1'b1;
    step(20'h0, 5'h0, ST_RST, rbit(), rop());
  endtask

  task automatic run_instr(input logic [4:0] op, input int fw, input int mw, input bit abort5);
    logic [19:0] f1;
    int          c;
    c  = cls_of(op);
    f1 = M_ZLOW | M_READ | M_MDRREAD | M_MDRIN;
    step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'h0, ST_T0, rbit(), rop());
    for (int i = 0; i < fw; i++) step(f1 | ((i == 0) ? M_PCIN : 20'h0), 5'h0, ST_T1, 1'b0, rop());
    step(f1 | ((fw == 0) ? M_PCIN : 20'h0), 5'h0, ST_T1, 1'b1, rop());
    step(M_MDROUT | M_IRIN, 5'h0, ST_T2, rbit(), rop());
    case (c)
      C_LD, C_LDI, C_ST: begin
        step(M_GRB | M_BAOUT | M_YIN, 5'h0, ST_T3, rbit(), op);
        step(M_COUT | M_ZIN, ADD, ST_T4, rbit(), rop());
        if (abort5) begin
          do_reset(2);
        end else if (c == C_LDI) begin
          step(M_ZLOW | M_GRA | M_RIN, 5'h0, ST_T5, rbit(), rop());
        end else begin
          step(M_ZLOW | M_MARIN, 5'h0, ST_T5, rbit(), rop());
          if (c == C_LD) begin
            for (int i = 0; i < mw; i++)
              step(M_READ | M_MDRREAD | M_MDRIN, 5'h0, ST_T6, 1'b0, rop());
            step(M_READ | M_MDRREAD | M_MDRIN, 5'h0, ST_T6, 1'b1, rop());
            step(M_MDROUT | M_GRA | M_RIN, 5'h0, ST_T7, rbit(), rop());
          end else begin
            step(M_GRA | M_ROUT | M_MDRIN, 5'h0, ST_T6, rbit(), rop());
            for (int i = 0; i < mw; i++) step(M_WRITE, 5'h0, ST_T7, 1'b0, rop());
            step(M_WRITE, 5'h0, ST_T7, 1'b1, rop());
          end
        end
      end
      C_R, C_I: begin
        step(M_GRB | M_ROUT | M_YIN, 5'h0, ST_T3, rbit(), op);
        if (c == C_R) step(M_GRC | M_ROUT | M_ZIN, op, ST_T4, rbit(), rop());
        else          step(M_COUT | M_ZIN, op, ST_T4, rbit(), rop());
        step(M_ZLOW | M_GRA | M_RIN, 5'h0, ST_T5, rbit(), rop());
      end
      C_HALT: begin
        step(20'h0, 5'h0, ST_T3, rbit(), op);
        for (int i = 0; i < 3; i++) step(20'h0, 5'h0, ST_HALT, rbit(), rop());
        do_reset(1);
      end
      default: begin
        step(20'h0, 5'h0, ST_T3, rbit(), op);
        if (c == C_BAD) ill_m = 1'b1;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    ill_m     = 1'b0;
    clr       = 1'b0;
    mem_ready = 1'b0;
    ir_opcode = 5'h0;
    @(posedge clk);
    #1;
    do_reset(3);
    run_instr(5'b00001, 0, 0, 1'b0);  // ldi
    run_instr(5'b00000, 0, 3, 1'b0);  // ld, three memory wait cycles
    run_instr(5'b00010, 0, 2, 1'b0);  // st
    run_instr(5'b00011, 0, 0, 1'b0);  // add
    run_instr(5'b01110, 0, 0, 1'b0);  // ori
    run_instr(5'b11010, 2, 0, 1'b0);  // nop with stalled fetch
    run_instr(5'b11111, 1, 0, 1'b0);  // unsupported opcode
    run_instr(5'b11010, 0, 0, 1'b0);  // illegal stays set
    run_instr(5'b00000, 1, 1, 1'b1);  // ld aborted by clr in T5
    run_instr(5'b00001, 0, 0, 1'b0);
    run_instr(5'b11011, 0, 0, 1'b0);  // halt, then reset
    for (int k = 0; k < 80; k++) begin
      run_instr(rop(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
